// File: rtl/axi_vga_capture.sv
// axi_vga_capture: samples a parallel VGA stream, packs visible pixels into
// DataWidth-bit words (pixel 0 in the LSBs) and hands them out through a
// fall-through FIFO on a valid/ready stream.
module axi_vga_capture #(
    parameter int RedWidth    = 5,
    parameter int GreenWidth  = 6,
    parameter int BlueWidth   = 5,
    parameter int HCountWidth = 12,
    parameter int VCountWidth = 12,
    parameter int DataWidth   = 64,
    parameter int FifoDepth   = 8,
    parameter bit SyncActLow  = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   pix_en_i,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
    input  logic [RedWidth-1:0]    red_i,
    input  logic [GreenWidth-1:0]  green_i,
    input  logic [BlueWidth-1:0]   blue_i,
    input  logic [HCountWidth-1:0] cfg_hback_i,
    input  logic [HCountWidth-1:0] cfg_hvis_i,
    input  logic [VCountWidth-1:0] cfg_vback_i,
    input  logic [VCountWidth-1:0] cfg_vvis_i,
    output logic [DataWidth-1:0]   data_o,
    output logic                   sof_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   frame_done_o,
    output logic                   overflow_o,
    output logic                   timing_err_o
);
    localparam int PixW       = RedWidth + GreenWidth + BlueWidth;
    localparam int PixPerWord = DataWidth / PixW;
    localparam int PcW        = (PixPerWord > 1) ? $clog2(PixPerWord) : 1;
    localparam int AW         = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CW         = $clog2(FifoDepth + 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

    state_t                 state;
    logic                   hs_act, vs_act, hs_prev, vs_prev, hs_trail, vs_trail;
    logic [HCountWidth-1:0] hcnt, cur_h, sh_hback, sh_hvis;
    logic [VCountWidth-1:0] vcnt, cur_v, sh_vback, sh_vvis;
    logic [HCountWidth:0]   h_end;
    logic [VCountWidth:0]   v_end;
    logic                   h_vis, v_vis, pix_vis, last_pix;
    logic                   en_q, en_rise;
    logic [PixW-1:0]        pix;
    logic [DataWidth-1:0]   pack_data, pack_next, push_data;
    logic [PcW-1:0]         pack_cnt;
    logic                   pack_sof, first_pix, push_vld, push_sof;
    logic [DataWidth:0]     mem [FifoDepth];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   full, pop, do_push;

    assign hs_act   = SyncActLow ? ~hsync_i : hsync_i;
    assign vs_act   = SyncActLow ? ~vsync_i : vsync_i;
    assign hs_trail = pix_en_i & hs_prev & ~hs_act;
    assign vs_trail = pix_en_i & vs_prev & ~vs_act;
    assign en_rise  = enable_i & ~en_q;
    assign pix      = {red_i, green_i, blue_i};

    // Position of the current sample: hsync trail restarts the line, vsync trail
    // parks vcnt at all-ones so the first full line after it becomes line 0.
    assign cur_h = hs_trail ? '0 : ((hcnt == '1) ? hcnt : hcnt + HCountWidth'(1));
    assign cur_v = vs_trail ? '1 : (hs_trail ? vcnt + VCountWidth'(1) : vcnt);

    assign h_end    = {1'b0, sh_hback} + {1'b0, sh_hvis};
    assign v_end    = {1'b0, sh_vback} + {1'b0, sh_vvis};
    assign h_vis    = ({1'b0, cur_h} >= {1'b0, sh_hback}) && ({1'b0, cur_h} < h_end);
    assign v_vis    = ({1'b0, cur_v} >= {1'b0, sh_vback}) && ({1'b0, cur_v} < v_end);
    assign pix_vis  = pix_en_i & h_vis & v_vis & ~hs_act & ~vs_act;
    assign last_pix = pix_vis && ({1'b0, cur_h} == h_end - (HCountWidth+1)'(1))
                              && ({1'b0, cur_v} == v_end - (VCountWidth+1)'(1));

    // Insert the current pixel into its lane of the word being assembled
    always_comb begin
        pack_next = pack_data;
        pack_next[int'(pack_cnt) * PixW +: PixW] = pix;
    end

    // Sync edge history, position counters and frame-start config shadow
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_prev  <= 1'b0;
            vs_prev  <= 1'b0;
            hcnt     <= '0;
            vcnt     <= '0;
            sh_hback <= '0;
            sh_hvis  <= '0;
            sh_vback <= '0;
            sh_vvis  <= '0;
        end else if (pix_en_i) begin
            hs_prev <= hs_act;
            vs_prev <= vs_act;
            hcnt    <= cur_h;
            vcnt    <= cur_v;
            if (vs_trail) begin
                sh_hback <= cfg_hback_i;
                sh_hvis  <= cfg_hvis_i;
                sh_vback <= cfg_vback_i;
                sh_vvis  <= cfg_vvis_i;
            end
        end
    end

    // Capture FSM and pixel packer; completed words go out through a one-cycle push register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            en_q         <= 1'b0;
            pack_data    <= '0;
            pack_cnt     <= '0;
            pack_sof     <= 1'b0;
            first_pix    <= 1'b0;
            push_vld     <= 1'b0;
            push_data    <= '0;
            push_sof     <= 1'b0;
            frame_done_o <= 1'b0;
            timing_err_o <= 1'b0;
        end else begin
            en_q         <= enable_i;
            push_vld     <= 1'b0;
            frame_done_o <= 1'b0;
            if (en_rise) timing_err_o <= 1'b0;
            if (!enable_i) begin
                state     <= IDLE;
                pack_data <= '0;
                pack_cnt  <= '0;
                pack_sof  <= 1'b0;
                first_pix <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_VS;
                    WAIT_VS: begin
                        if (vs_trail) begin
                            state     <= ACTIVE;
                            pack_data <= '0;
                            pack_cnt  <= '0;
                            pack_sof  <= 1'b0;
                            first_pix <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (vs_trail) begin
                            // frame cut short: drop the partial word and restart
                            pack_data <= '0;
                            pack_cnt  <= '0;
                            pack_sof  <= 1'b0;
                            first_pix <= 1'b1;
                            if (sh_hvis != '0 && sh_vvis != '0) timing_err_o <= 1'b1;
                        end else if (pix_vis) begin
                            first_pix <= 1'b0;
                            if (pack_cnt == PcW'(PixPerWord - 1) || last_pix) begin
                                push_vld     <= 1'b1;
                                push_data    <= pack_next;
                                push_sof     <= pack_sof | first_pix;
                                pack_data    <= '0;
                                pack_cnt     <= '0;
                                pack_sof     <= 1'b0;
                                frame_done_o <= last_pix;
                                if (last_pix) state <= WAIT_VS;
                            end else begin
                                pack_data <= pack_next;
                                pack_cnt  <= pack_cnt + PcW'(1);
                                pack_sof  <= pack_sof | first_pix;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign full    = (count == CW'(FifoDepth));
    assign valid_o = (count != '0);
    assign pop     = valid_o & ready_i;
    assign do_push = push_vld & (~full | pop);
    assign data_o  = valid_o ? mem[rd_ptr][DataWidth-1:0] : '0;
    assign sof_o   = valid_o & mem[rd_ptr][DataWidth];

    // FIFO storage, not reset: pointers and count define what is valid
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= {push_sof, push_data};
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(FifoDepth - 1)) ? '0 : wr_ptr + AW'(1);
            if (pop)     rd_ptr <= (rd_ptr == AW'(FifoDepth - 1)) ? '0 : rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (en_rise) overflow_o <= 1'b0;
            if (push_vld && !do_push) overflow_o <= 1'b1;
        end
    end

endmodule
